cp0_regfile: RTL and testbench

- Coprocessor-0 register file that sits directly downstream of the dual-issue exception arbitration stage and consumes its resolved outputs.
- Commits EPC, Cause.BD, Cause.ExcCode, BadVAddr and Status.EXL on exceptions and clears EXL on ERET.
- Serves MFC0/MTC0 accesses and runs the Count/Compare timer.
- Feeds back status_exl (exception-level flag), the EPC return target and the pending-interrupt request that drives the first-slot soft-interrupt exception bit.

---
 rtl/cp0_regfile_if.sv | 40 ++++
 rtl/cp0_regfile.sv | 136 +++++++++++++
 tb/tb_cp0_regfile.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_if.sv
// CP0 register file bus: MTC0/MFC0 access, exception commit,
// interrupt lines and register feedback toward the pipeline.
interface cp0_regfile_if;
   logic        mtc0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        has_exp;
   logic        exp_clean;
   logic        exp_is_in_delayslot;
   logic [31:0] cp0_epc_in;
   logic        wen_badaddress;
   logic [31:0] cp0_badaddress_in;
   logic [4:0]  cp0_cause_code;
   logic [5:0]  ext_int;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_epc_out;
   logic        status_exl;
   logic        int_pending;

   modport master (
      output mtc0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      output has_exp, exp_clean, exp_is_in_delayslot,
      output cp0_epc_in, wen_badaddress, cp0_badaddress_in,
      output cp0_cause_code, ext_int,
      input  cp0_rdata, cp0_status, cp0_cause,
      input  cp0_epc_out, status_exl, int_pending
   );

   modport slave (
      input  mtc0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      input  has_exp, exp_clean, exp_is_in_delayslot,
      input  cp0_epc_in, wen_badaddress, cp0_badaddress_in,
      input  cp0_cause_code, ext_int,
      output cp0_rdata, cp0_status, cp0_cause,
      output cp0_epc_out, status_exl, int_pending
   );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr/Count/Compare.
// Define CP0_TIMER_INT_EN to enable the Count==Compare timer interrupt (TI).
module cp0_regfile #(
   parameter int COUNT_DIV = 2,
   parameter bit RESET_BEV = 1'b1
) (
   input logic         clk,
   input logic         resetn,
   cp0_regfile_if.slave bus
);

   localparam logic [3:0] DIV_MAX = 4'(COUNT_DIV - 1);

   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic        ti;
   logic [5:0]  ip_ext;
   logic [1:0]  ip_sw;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic [3:0]  div_cnt;

   logic exc;
   logic eret;
   logic wr;
   logic tick;
   logic [31:0] status;
   logic [31:0] cause;

   assign exc  = bus.has_exp & ~bus.exp_clean;
   assign eret = bus.has_exp & bus.exp_clean;
   assign wr   = bus.mtc0_we & ~bus.has_exp;
   assign tick = (div_cnt == DIV_MAX);

   assign status = {9'b0, RESET_BEV, 6'b0, im, 6'b0, exl, ie};
   assign cause  = {bd, ti, 14'b0, ip_ext[5] | ti, ip_ext[4:0],
                    ip_sw, 1'b0, exc_code, 2'b0};

   // Exception/ERET commit has priority over MTC0 to Status/Cause/EPC/Compare.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         im       <= 8'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip_ext   <= 6'd0;
         ip_sw    <= 2'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
         badvaddr <= 32'd0;
         compare  <= 32'd0;
      end else begin
         ip_ext <= bus.ext_int;
         if (exc) begin
            exc_code <= bus.cp0_cause_code;
            exl      <= 1'b1;
            if (!exl) begin
               epc <= bus.cp0_epc_in;
               bd  <= bus.exp_is_in_delayslot;
            end
            if (bus.wen_badaddress)
               badvaddr <= bus.cp0_badaddress_in;
         end else if (eret) begin
            exl <= 1'b0;
         end else if (wr) begin
            case (bus.cp0_waddr)
               5'd11: compare <= bus.cp0_wdata;
               5'd12: begin
                  im  <= bus.cp0_wdata[15:8];
                  exl <= bus.cp0_wdata[1];
                  ie  <= bus.cp0_wdata[0];
               end
               5'd13: ip_sw <= bus.cp0_wdata[9:8];
               5'd14: epc   <= bus.cp0_wdata;
               default: ;
            endcase
         end
      end
   end

   // Count advances once per COUNT_DIV cycles; an MTC0 load restarts the divider.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count   <= 32'd0;
         div_cnt <= 4'd0;
      end else if (wr && bus.cp0_waddr == 5'd9) begin
         count   <= bus.cp0_wdata;
         div_cnt <= 4'd0;
      end else if (tick) begin
         count   <= count + 32'd1;
         div_cnt <= 4'd0;
      end else begin
         div_cnt <= div_cnt + 4'd1;
      end
   end

`ifdef CP0_TIMER_INT_EN
   // TI latches on a Count/Compare match; a Compare write clears it and wins.
   always_ff @(posedge clk) begin
      if (!resetn)
         ti <= 1'b0;
      else if (wr && bus.cp0_waddr == 5'd11)
         ti <= 1'b0;
      else if (count == compare)
         ti <= 1'b1;
   end
`else
   assign ti = 1'b0;
`endif

   // MFC0 read mux; unimplemented registers read zero.
   always_comb begin
      bus.cp0_rdata = 32'd0;
      case (bus.cp0_raddr)
         5'd8:  bus.cp0_rdata = badvaddr;
         5'd9:  bus.cp0_rdata = count;
         5'd11: bus.cp0_rdata = compare;
         5'd12: bus.cp0_rdata = status;
         5'd13: bus.cp0_rdata = cause;
         5'd14: bus.cp0_rdata = epc;
         default: bus.cp0_rdata = 32'd0;
      endcase
   end

   assign bus.cp0_status  = status;
   assign bus.cp0_cause   = cause;
   assign bus.cp0_epc_out = epc;
   assign bus.status_exl  = exl;
   assign bus.int_pending = ie & ~exl & |(cause[15:8] & im);

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed testbench for cp0_regfile: reset, exception/ERET commit,
// MTC0 collision, interrupt path, Count/Compare timer and Count wrap.
module tb_cp0_regfile;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef CP0_TIMER_INT_EN
   localparam logic [31:0] TI_CAUSE = 32'h4000_8000;
`else
   localparam logic [31:0] TI_CAUSE = 32'h0000_0000;
`endif

   cp0_regfile_if bus ();

   cp0_regfile #(.COUNT_DIV(2), .RESET_BEV(1'b1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, input string tag,
                     input logic [31:0] exp);
      bus.cp0_raddr = a;
      #1;
      chk(tag, bus.cp0_rdata, exp);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.mtc0_we   = 1'b1;
      bus.cp0_waddr = a;
      bus.cp0_wdata = d;
      step();
      bus.mtc0_we   = 1'b0;
   endtask

   task automatic raise(input logic [31:0] pc, input logic ds,
                        input logic [4:0] code, input logic wb,
                        input logic [31:0] ba);
      bus.has_exp             = 1'b1;
      bus.exp_clean           = 1'b0;
      bus.cp0_epc_in          = pc;
      bus.exp_is_in_delayslot = ds;
      bus.cp0_cause_code      = code;
      bus.wen_badaddress      = wb;
      bus.cp0_badaddress_in   = ba;
      step();
      bus.has_exp        = 1'b0;
      bus.wen_badaddress = 1'b0;
   endtask

   initial begin
      resetn                  = 1'b0;
      bus.mtc0_we             = 1'b0;
      bus.cp0_waddr           = 5'd0;
      bus.cp0_wdata           = 32'd0;
      bus.cp0_raddr           = 5'd0;
      bus.has_exp             = 1'b0;
      bus.exp_clean           = 1'b0;
      bus.exp_is_in_delayslot = 1'b0;
      bus.cp0_epc_in          = 32'd0;
      bus.wen_badaddress      = 1'b0;
      bus.cp0_badaddress_in   = 32'd0;
      bus.cp0_cause_code      = 5'd0;
      bus.ext_int             = 6'd0;

      // reset
      repeat (3) step();
      chk("rst_status", bus.cp0_status, 32'h0040_0000);
      chk("rst_cause", bus.cp0_cause, 32'h0);
      chk("rst_epc", bus.cp0_epc_out, 32'h0);
      chk("rst_exl", {31'b0, bus.status_exl}, 32'h0);
      chk("rst_intp", {31'b0, bus.int_pending}, 32'h0);
      rd(5'd8, "rst_badv", 32'h0);
      rd(5'd9, "rst_count", 32'h0);
      rd(5'd11, "rst_compare", 32'h0);

      resetn = 1'b1;
      step();
      mtc0(5'd11, 32'd1000);

      // first exception
      raise(32'hBFC0_0100, 1'b1, 5'h0C, 1'b0, 32'hDEAD_BEEF);
      chk("exc_epc", bus.cp0_epc_out, 32'hBFC0_0100);
      chk("exc_cause", bus.cp0_cause, 32'h8000_0030);
      chk("exc_exl", {31'b0, bus.status_exl}, 32'h1);
      chk("exc_status", bus.cp0_status, 32'h0040_0002);
      rd(5'd8, "exc_badv", 32'h0);

      // nested exception keeps EPC/BD, updates code and BadVAddr
      raise(32'h0000_1234, 1'b0, 5'h04, 1'b1, 32'hDEAD_BEEF);
      chk("nest_epc", bus.cp0_epc_out, 32'hBFC0_0100);
      chk("nest_cause", bus.cp0_cause, 32'h8000_0010);
      rd(5'd8, "nest_badv", 32'hDEAD_BEEF);

      // ERET with colliding MTC0 Status
      bus.has_exp   = 1'b1;
      bus.exp_clean = 1'b1;
      mtc0(5'd12, 32'h0000_FF01);
      bus.has_exp   = 1'b0;
      bus.exp_clean = 1'b0;
      chk("eret_exl", {31'b0, bus.status_exl}, 32'h0);
      chk("eret_status", bus.cp0_status, 32'h0040_0000);
      chk("eret_epc", bus.cp0_epc_out, 32'hBFC0_0100);

      // MTC0 EPC
      mtc0(5'd14, 32'h8000_1000);
      chk("mtc0_epc", bus.cp0_epc_out, 32'h8000_1000);

      // interrupt path
      mtc0(5'd12, 32'h0000_8001);
      chk("im_status", bus.cp0_status, 32'h0040_8001);
      chk("im_intp0", {31'b0, bus.int_pending}, 32'h0);
      bus.ext_int = 6'b100000;
      #1;
      chk("int_pre", {31'b0, bus.int_pending}, 32'h0);
      step();
      chk("int_cause", bus.cp0_cause, 32'h8000_8010);
      chk("int_intp", {31'b0, bus.int_pending}, 32'h1);

      raise(32'h0000_2000, 1'b0, 5'h00, 1'b0, 32'h0);
      chk("exl_intp", {31'b0, bus.int_pending}, 32'h0);
      chk("exl_epc", bus.cp0_epc_out, 32'h0000_2000);
      chk("exl_cause", bus.cp0_cause, 32'h0000_8000);
      chk("exl_status", bus.cp0_status, 32'h0040_8003);
      bus.ext_int = 6'd0;
      rd(5'd15, "rd_unimpl", 32'h0);

      // timer
      resetn = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      step();
      mtc0(5'd9, 32'h0000_1000);
      mtc0(5'd11, 32'd4);
      mtc0(5'd9, 32'd0);
      repeat (7) step();
      rd(5'd9, "cnt_3", 32'd3);
      step();
      rd(5'd9, "cnt_4", 32'd4);
      chk("ti_pre", bus.cp0_cause, 32'h0);
      step();
      chk("ti_set", bus.cp0_cause, TI_CAUSE);
      mtc0(5'd11, 32'd100);
      chk("ti_clr", bus.cp0_cause, 32'h0);
      rd(5'd11, "cmp_rd", 32'd100);

      // wrap
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, "wrap_0", 32'hFFFF_FFFF);
      step();
      rd(5'd9, "wrap_1", 32'hFFFF_FFFF);
      step();
      rd(5'd9, "wrap_2", 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
